// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush controller for the 5-stage MIPS core
module hazard_unit #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREQMEM,
    input  logic             haltMEM,
    input  logic [4:0]       rsID,
    input  logic [4:0]       rtID,
    input  logic             usesRtID,
    input  logic [4:0]       destEX,
    input  logic             wenEX,
    input  logic             memReadEX,
    input  logic             brTakenEX,
    output logic             pcEn,
    output logic             ifidEn,
    output logic             idexEn,
    output logic             exmemEn,
    output logic             memwbEn,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             exmemFlush,
    output logic             memwbFlush,
    output logic [CNT_W-1:0] stallCnt,
    output logic             memTimeout
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t            state, nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic              memStall;
    logic              ldUse;
    logic              waiting;

    assign memStall = dREQMEM & ~dhit;
    assign ldUse    = memReadEX & wenEX & (destEX != 5'd0) &
                      ((destEX == rsID) | (usesRtID & (destEX == rtID)));
    // The stalled cycle that enters MEMWAIT already counts toward the watchdog.
    assign waiting  = memStall & ~haltMEM & (state != HALT);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            RUN, MEMWAIT: begin
                if (haltMEM) begin
                    nextState = HALT;
                end else if (memStall) begin
                    nextState = MEMWAIT;
                end else begin
                    nextState = RUN;
                end
            end
            HALT:    nextState = HALT;
            default: nextState = RUN;
        endcase
    end

    always_comb begin
        pcEn       = 1'b0;
        ifidEn     = 1'b0;
        idexEn     = 1'b0;
        exmemEn    = 1'b0;
        memwbEn    = 1'b0;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        exmemFlush = 1'b0;
        memwbFlush = 1'b0;
        if (nRST && (state != HALT) && !haltMEM) begin
            if (memStall) begin
                // A pending redirect stays in the frozen EX/MEM and is honoured once dhit arrives.
                memwbEn    = 1'b1;
                memwbFlush = 1'b1;
            end else if (brTakenEX) begin
                pcEn      = 1'b1;
                ifidEn    = 1'b1;
                idexEn    = 1'b1;
                exmemEn   = 1'b1;
                memwbEn   = 1'b1;
                ifidFlush = 1'b1;
                idexFlush = 1'b1;
            end else if (ldUse) begin
                idexEn    = 1'b1;
                exmemEn   = 1'b1;
                memwbEn   = 1'b1;
                idexFlush = 1'b1;
            end else if (!ihit) begin
                ifidEn    = 1'b1;
                idexEn    = 1'b1;
                exmemEn   = 1'b1;
                memwbEn   = 1'b1;
                ifidFlush = 1'b1;
            end else begin
                pcEn    = 1'b1;
                ifidEn  = 1'b1;
                idexEn  = 1'b1;
                exmemEn = 1'b1;
                memwbEn = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stallCnt   <= '0;
            memTimeout <= 1'b0;
            waitCnt    <= '0;
        end else begin
            if (!pcEn && (state != HALT) && (stallCnt != {CNT_W{1'b1}})) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if (waiting) begin
                if (waitCnt == WAIT_MAX) begin
                    memTimeout <= 1'b1;
                end else begin
                    waitCnt <= waitCnt + WAIT_W'(1);
                end
            end else begin
                waitCnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - randomized and directed bench for hazard_unit
module tb_hazard_unit;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             nRST, ihit, dhit, dREQMEM, haltMEM;
    logic [4:0]       rsID, rtID, destEX;
    logic             usesRtID, wenEX, memReadEX, brTakenEX;
    logic             pcEn, ifidEn, idexEn, exmemEn, memwbEn;
    logic             ifidFlush, idexFlush, exmemFlush, memwbFlush;
    logic [CNT_W-1:0] stallCnt;
    logic             memTimeout;
    logic [8:0]       obs;

    int checks   = 0;
    int failures = 0;

    // reference state: halted flag, stall count, consecutive data-wait run, timeout flag
    bit mHalted = 0;
    int mCnt    = 0;
    int mRun    = 0;
    bit mTo     = 0;

    localparam logic [8:0] O_NONE  = 9'b000000000;
    localparam logic [8:0] O_RUN   = 9'b111110000;
    localparam logic [8:0] O_MEM   = 9'b000010001;
    localparam logic [8:0] O_BR    = 9'b111111100;
    localparam logic [8:0] O_LD    = 9'b001110100;
    localparam logic [8:0] O_IMISS = 9'b011111000;

    hazard_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREQMEM(dREQMEM),
        .haltMEM(haltMEM), .rsID(rsID), .rtID(rtID), .usesRtID(usesRtID),
        .destEX(destEX), .wenEX(wenEX), .memReadEX(memReadEX), .brTakenEX(brTakenEX),
        .pcEn(pcEn), .ifidEn(ifidEn), .idexEn(idexEn), .exmemEn(exmemEn), .memwbEn(memwbEn),
        .ifidFlush(ifidFlush), .idexFlush(idexFlush), .exmemFlush(exmemFlush),
        .memwbFlush(memwbFlush), .stallCnt(stallCnt), .memTimeout(memTimeout)
    );

    assign obs = {pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush, exmemFlush, memwbFlush};

    always #5 CLK = ~CLK;

    function automatic logic [8:0] model_outs();
        bit isLoadUse;
        if (!nRST || mHalted || haltMEM) return O_NONE;
        if (dREQMEM && !dhit) return O_MEM;
        if (brTakenEX) return O_BR;
        isLoadUse = memReadEX && wenEX && destEX != 0 &&
                    (destEX == rsID || (usesRtID && destEX == rtID));
        if (isLoadUse) return O_LD;
        if (!ihit) return O_IMISS;
        return O_RUN;
    endfunction

    task automatic clear_inputs();
        ihit = 1; dhit = 1; dREQMEM = 0; haltMEM = 0; rsID = 0; rtID = 0;
        usesRtID = 0; destEX = 0; wenEX = 0; memReadEX = 0; brTakenEX = 0;
    endtask

    // apply one rising edge to the reference, then return to the falling edge
    task automatic advance();
        logic [8:0] o;
        #1;
        o = model_outs();
        if (!nRST) begin
            mHalted = 0; mCnt = 0; mTo = 0; mRun = 0;
        end else if (!mHalted) begin
            if (!o[8] && mCnt < CNT_MAX) mCnt++;
            if (haltMEM) begin
                mHalted = 1; mRun = 0;
            end else if (dREQMEM && !dhit) begin
                mRun++;
                if (mRun >= TIMEOUT) mTo = 1;
            end else begin
                mRun = 0;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 0;
        advance();
        nRST = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 0;
        for (int i = 0; i < 2; i++) begin
            advance();
            #1;
            checks++; if (obs !== O_NONE) begin failures++; $display("FAIL reset_outs got=%b exp=%b", obs, O_NONE); end
            checks++; if (stallCnt !== 0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stallCnt); end
            checks++; if (memTimeout !== 0) begin failures++; $display("FAIL reset_to got=%b exp=0", memTimeout); end
        end
        nRST = 1;
        #1;
        checks++; if (obs !== O_RUN) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs, O_RUN); end
        advance();
    endtask

    task automatic test_load_use();
        do_reset();
        memReadEX = 1; wenEX = 1; destEX = 8; rsID = 8;
        #1;
        checks++; if (obs !== O_LD) begin failures++; $display("FAIL lu_stall got=%b exp=%b", obs, O_LD); end
        advance();
        memReadEX = 0; wenEX = 0; destEX = 0; rsID = 0;
        #1;
        checks++; if (obs !== O_RUN) begin failures++; $display("FAIL lu_resume got=%b exp=%b", obs, O_RUN); end
        checks++; if (stallCnt !== 1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stallCnt); end
        advance();
    endtask

    task automatic test_no_false_stall();
        do_reset();
        memReadEX = 1; wenEX = 1; destEX = 0; rsID = 0; rtID = 0; usesRtID = 1;
        #1;
        checks++; if (obs !== O_RUN) begin failures++; $display("FAIL r0_nostall got=%b exp=%b", obs, O_RUN); end
        destEX = 9; rsID = 3; rtID = 9; usesRtID = 0;
        #1;
        checks++; if (obs !== O_RUN) begin failures++; $display("FAIL rt_unused got=%b exp=%b", obs, O_RUN); end
        usesRtID = 1;
        #1;
        checks++; if (obs !== O_LD) begin failures++; $display("FAIL rt_used got=%b exp=%b", obs, O_LD); end
        wenEX = 0;
        #1;
        checks++; if (obs !== O_RUN) begin failures++; $display("FAIL no_wen got=%b exp=%b", obs, O_RUN); end
        advance();
    endtask

    task automatic test_mem_wait();
        do_reset();
        dREQMEM = 1; dhit = 0; brTakenEX = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (obs !== O_MEM) begin failures++; $display("FAIL memwait_%0d got=%b exp=%b", i, obs, O_MEM); end
            advance();
        end
        dhit = 1;
        #1;
        checks++; if (obs !== O_BR) begin failures++; $display("FAIL memwait_exit got=%b exp=%b", obs, O_BR); end
        checks++; if (stallCnt !== 5) begin failures++; $display("FAIL memwait_cnt got=%0d exp=5", stallCnt); end
        checks++; if (memTimeout !== 1) begin failures++; $display("FAIL memwait_to got=%b exp=1", memTimeout); end
        advance();
        do_reset();
        dREQMEM = 1; dhit = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) advance();
        dhit = 1;
        #1;
        checks++; if (memTimeout !== 0) begin failures++; $display("FAIL short_wait_to got=%b exp=0", memTimeout); end
        advance();
    endtask

    task automatic test_branch_priority();
        do_reset();
        brTakenEX = 1; memReadEX = 1; wenEX = 1; destEX = 5; rsID = 5; ihit = 0;
        #1;
        checks++; if (obs !== O_BR) begin failures++; $display("FAIL br_prio got=%b exp=%b", obs, O_BR); end
        brTakenEX = 0; memReadEX = 0;
        #1;
        checks++; if (obs !== O_IMISS) begin failures++; $display("FAIL imiss got=%b exp=%b", obs, O_IMISS); end
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        ihit = 0;
        for (int i = 0; i < CNT_MAX + 5; i++) advance();
        #1;
        checks++; if (stallCnt !== CNT_W'(CNT_MAX)) begin failures++; $display("FAIL sat_cnt got=%0d exp=%0d", stallCnt, CNT_MAX); end
    endtask

    task automatic test_halt();
        logic [CNT_W-1:0] snap;
        do_reset();
        ihit = 0;
        advance();
        haltMEM = 1;
        #1;
        checks++; if (obs !== O_NONE) begin failures++; $display("FAIL halt_entry got=%b exp=%b", obs, O_NONE); end
        advance();
        snap = stallCnt;
        haltMEM = 0; ihit = 0; dREQMEM = 1; dhit = 0;
        for (int i = 0; i < 6; i++) begin
            advance();
            #1;
            checks++; if (obs !== O_NONE) begin failures++; $display("FAIL halt_outs_%0d got=%b exp=%b", i, obs, O_NONE); end
        end
        checks++; if (stallCnt !== snap) begin failures++; $display("FAIL halt_frozen got=%0d exp=%0d", stallCnt, snap); end
        checks++; if (memTimeout !== 0) begin failures++; $display("FAIL halt_to got=%b exp=0", memTimeout); end
        nRST = 0;
        advance();
        #1;
        checks++; if (stallCnt !== 0) begin failures++; $display("FAIL halt_reset_cnt got=%0d exp=0", stallCnt); end
        nRST = 1; clear_inputs();
        #1;
        checks++; if (obs !== O_RUN) begin failures++; $display("FAIL halt_reset_run got=%b exp=%b", obs, O_RUN); end
        advance();
    endtask

    task automatic test_random();
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            nRST      = ($urandom_range(0, 59) != 0);
            haltMEM   = ($urandom_range(0, 39) == 0);
            ihit      = ($urandom_range(0, 3) != 0);
            dREQMEM   = $urandom_range(0, 1);
            dhit      = ($urandom_range(0, 2) == 0);
            brTakenEX = ($urandom_range(0, 5) == 0);
            memReadEX = $urandom_range(0, 1);
            wenEX     = ($urandom_range(0, 3) != 0);
            usesRtID  = $urandom_range(0, 1);
            destEX    = 5'($urandom_range(0, 3));
            rsID      = 5'($urandom_range(0, 3));
            rtID      = 5'($urandom_range(0, 3));
            #1;
            e = model_outs();
            checks++; if (obs !== e) begin failures++; $display("FAIL rand_outs_%0d got=%b exp=%b", i, obs, e); end
            checks++; if (stallCnt !== CNT_W'(mCnt)) begin failures++; $display("FAIL rand_cnt_%0d got=%0d exp=%0d", i, stallCnt, mCnt); end
            checks++; if (memTimeout !== mTo) begin failures++; $display("FAIL rand_to_%0d got=%b exp=%b", i, memTimeout, mTo); end
            advance();
        end
    endtask

    initial begin
        clear_inputs();
        nRST = 0;
        @(negedge CLK);
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_mem_wait();
        test_branch_priority();
        test_saturation();
        test_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
